ps2_command_tx_retry: RTL and testbench
=======================================

# ps2_command_tx_retry

Host-to-device PS/2 command transmitter with parametrised timing, acknowledge checking and automatic retry. It sits between the keyboard/mouse controller logic and the open-drain PS2_CLK/PS2_DAT pins, beside the PS/2 receive path that supplies the clock-edge strobes. Unlike the fixed-timing transmitter it replaces, it checks the device ACK bit and resends on NACK or transfer timeout. It reports success, no-device timeout and exhausted-retry failure separately.

## Interface
- INHIBIT_CYCLES, 5050: clk cycles PS2_CLK is held low to request-to-send (101 us at 50 MHz).
- START_TIMEOUT_CYCLES, 750000: max cycles waiting for the device's first clock (15 ms).
- XFER_TIMEOUT_CYCLES, 100000: max cycles from start of data to ACK (2 ms).
- MAX_RETRIES, 2: resend attempts after the first try; 0 disables retry.
- Counter widths are derived as $clog2(N+1) of each cycle parameter. RW = $clog2(MAX_RETRIES+1), minimum 1.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- the_command  in  8  byte to send; latched when leaving IDLE.
- send_command  in  1  level request; hold high until a result flag is seen, then drop.
- ps2_clk_posedge  in  1  one-cycle strobe, synchronised PS2_CLK rising edge.
- ps2_clk_negedge  in  1  one-cycle strobe, synchronised PS2_CLK falling edge.
- ps2_dat_in  in  1  synchronised PS2_DAT level.
- PS2_CLK  inout  1  open drain: drives 0 or z only.
- PS2_DAT  inout  1  open drain: drives 0 or z only. Drives a 1 data bit as z.
- busy  out  1  state not IDLE/DONE/ERROR.
- command_was_sent  out  1  high while in DONE.
- error_communication_timed_out  out  1  high while in ERROR with cause = start timeout.
- error_no_ack  out  1  high while in ERROR with cause = retries exhausted.
- retries_used  out  RW  resends performed for the current command.

## Operation
- States:
  - IDLE: latch {odd parity = ~^the_command, the_command} into a 9-bit shift image every cycle. Clear retries_used and the error cause. Go to INHIBIT when send_command=1.
  - INHIBIT: PS2_CLK=0. PS2_DAT=0 once counter >= INHIBIT_CYCLES/2, else z. Go to WAIT_CLK after exactly INHIBIT_CYCLES cycles.
  - WAIT_CLK: PS2_DAT=0, PS2_CLK=z.
    - On ps2_clk_negedge, go to DATA with bit index 0 and clear the transfer counter.
    - If START_TIMEOUT_CYCLES cycles pass with no negedge, go to ERROR with cause timeout. No retry.
  - DATA: PS2_DAT drives image[bit] (0 -> 0, 1 -> z). Each negedge increments bit. A negedge with bit=8 (parity) goes to STOP.
  - STOP: PS2_DAT=z (stop bit 1). Next negedge goes to ACK.
  - ACK: on ps2_clk_posedge, sample ps2_dat_in.
    - 0: go to DONE.
    - 1 (NACK): go to RETRY.
  - RETRY: one cycle.
    - If retries_used < MAX_RETRIES: increment retries_used, go to INHIBIT. The same latched byte is resent.
    - Else: go to ERROR with cause no_ack.
  - DONE / ERROR: hold. Go to IDLE when send_command=0.
- The transfer counter runs across DATA, STOP and ACK. It reaching XFER_TIMEOUT_CYCLES sends the FSM to RETRY, which is treated like a NACK.
- Simultaneous events: a clock edge strobe wins over a timeout in the same cycle.
- Dropping send_command mid-transfer does not abort. The result is produced, then IDLE follows immediately if send_command is still 0.
- Unused state encodings go to IDLE.

## Timing
- Reset (async, any state): state=IDLE, all counters 0, retries_used=0.
  - All flag outputs are 0 and busy=0.
  - PS2_CLK and PS2_DAT are released to z immediately, without waiting for clk.
- Pin drives and flags decode from registered state and counters: no combinational path from inputs to pins.
- Cycle 0 with send_command=1 in IDLE gives busy=1 at cycle 1, with PS2_CLK low from cycle 1 through INHIBIT_CYCLES.
- DATA output changes the cycle after the negedge strobe, so each bit is stable across the device's rising-edge sample.
- command_was_sent rises one cycle after the ACK posedge strobe. All flags fall one cycle after send_command=0.

## Test plan
Use INHIBIT_CYCLES=50, START_TIMEOUT_CYCLES=300, XFER_TIMEOUT_CYCLES=200, MAX_RETRIES=2 for all scenarios.
- Send 0xED; a device model clocks 11 edges and ACKs low -> PS2_CLK low exactly 50 cycles; the DAT sequence is 0,1,0,1,1,0,1,1,1, then parity 1 (as z), then stop z; command_was_sent=1; retries_used=0.
- Send 0xF4; no device clock -> error_communication_timed_out=1 at cycle 50+300+2 (±1); error_no_ack=0; the pins are released.
- Send 0xFF; the device NACKs twice then ACKs -> three full INHIBIT phases, each resending the same byte; command_was_sent=1; retries_used=2.
- Send 0xAA; the device always NACKs -> error_no_ack=1, retries_used=2; dropping send_command returns busy=0 and all flags 0 after 1 cycle.
- Device stops clocking after bit 3 -> transfer timeout triggers a retry; the retry ACKs -> command_was_sent=1, retries_used=1.
- Assert reset in the middle of DATA -> PS2_CLK and PS2_DAT go to z without waiting for a clk edge; all outputs 0; a new send after reset completes normally.

Source files
------------

// File: rtl/ps2_command_tx_retry.sv
// PS/2 host-to-device command transmitter with request-to-send timing,
// device ACK checking, bounded automatic resend and separate result flags.
//
// Ports:
//   clk, reset                      system clock, asynchronous active-high reset
//   the_command[7:0]                byte to send, captured while idle
//   send_command                    level request, held until a result flag is seen
//   ps2_clk_posedge/ps2_clk_negedge synchronised PS2_CLK edge strobes
//   ps2_dat_in                      synchronised PS2_DAT level
//   PS2_CLK, PS2_DAT                open-drain pins (drive 0 or release)
//   busy                            transfer in progress
//   command_was_sent                device acknowledged the byte
//   error_communication_timed_out   device never started clocking
//   error_no_ack                    every attempt was NACKed or stalled
//   retries_used[RW-1:0]            resends performed for the current command
module ps2_command_tx_retry #(
    parameter int unsigned INHIBIT_CYCLES       = 5050,
    parameter int unsigned START_TIMEOUT_CYCLES = 750000,
    parameter int unsigned XFER_TIMEOUT_CYCLES  = 100000,
    parameter int unsigned MAX_RETRIES          = 2,
    localparam int unsigned RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    the_command,
    input  logic          send_command,
    input  logic          ps2_clk_posedge,
    input  logic          ps2_clk_negedge,
    input  logic          ps2_dat_in,
    inout  wire           PS2_CLK,
    inout  wire           PS2_DAT,
    output logic          busy,
    output logic          command_was_sent,
    output logic          error_communication_timed_out,
    output logic          error_no_ack,
    output logic [RW-1:0] retries_used
);

    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned ST_W  = $clog2(START_TIMEOUT_CYCLES + 1);
    localparam int unsigned XF_W  = $clog2(XFER_TIMEOUT_CYCLES + 1);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_INHIBIT  = 4'd1,
        S_WAIT_CLK = 4'd2,
        S_DATA     = 4'd3,
        S_STOP     = 4'd4,
        S_ACK      = 4'd5,
        S_RETRY    = 4'd6,
        S_DONE     = 4'd7,
        S_ERROR    = 4'd8
    } state_t;

    state_t           state;
    logic [INH_W-1:0] inhibit_cnt;
    logic [ST_W-1:0]  start_cnt;
    logic [XF_W-1:0]  xfer_cnt;
    logic [3:0]       bit_idx;
    logic [8:0]       image;          // {odd parity, byte}, bit 0 sent first
    logic             cause_timeout;  // error cause: 1 = no device clock, 0 = no ACK

    // Transfer sequencer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            inhibit_cnt   <= '0;
            start_cnt     <= '0;
            xfer_cnt      <= '0;
            bit_idx       <= '0;
            image         <= '0;
            retries_used  <= '0;
            cause_timeout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    image         <= {~^the_command, the_command};
                    retries_used  <= '0;
                    cause_timeout <= 1'b0;
                    inhibit_cnt   <= '0;
                    if (send_command) begin
                        state <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (inhibit_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
                        state     <= S_WAIT_CLK;
                        start_cnt <= '0;
                    end else begin
                        inhibit_cnt <= inhibit_cnt + INH_W'(1);
                    end
                end
                S_WAIT_CLK: begin
                    if (ps2_clk_negedge) begin
                        state    <= S_DATA;
                        bit_idx  <= '0;
                        xfer_cnt <= '0;
                    end else if (start_cnt == ST_W'(START_TIMEOUT_CYCLES)) begin
                        state         <= S_ERROR;
                        cause_timeout <= 1'b1;
                    end else begin
                        start_cnt <= start_cnt + ST_W'(1);
                    end
                end
                // Edge strobes take priority over the transfer timeout
                S_DATA: begin
                    xfer_cnt <= xfer_cnt + XF_W'(1);
                    if (ps2_clk_negedge) begin
                        if (bit_idx == 4'd8) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end else if (xfer_cnt == XF_W'(XFER_TIMEOUT_CYCLES)) begin
                        state <= S_RETRY;
                    end
                end
                S_STOP: begin
                    xfer_cnt <= xfer_cnt + XF_W'(1);
                    if (ps2_clk_negedge) begin
                        state <= S_ACK;
                    end else if (xfer_cnt == XF_W'(XFER_TIMEOUT_CYCLES)) begin
                        state <= S_RETRY;
                    end
                end
                S_ACK: begin
                    xfer_cnt <= xfer_cnt + XF_W'(1);
                    if (ps2_clk_posedge) begin
                        state <= ps2_dat_in ? S_RETRY : S_DONE;
                    end else if (xfer_cnt == XF_W'(XFER_TIMEOUT_CYCLES)) begin
                        state <= S_RETRY;
                    end
                end
                // Resend the latched image or give up
                S_RETRY: begin
                    if (retries_used < RW'(MAX_RETRIES)) begin
                        retries_used <= retries_used + RW'(1);
                        inhibit_cnt  <= '0;
                        state        <= S_INHIBIT;
                    end else begin
                        cause_timeout <= 1'b0;
                        state         <= S_ERROR;
                    end
                end
                S_DONE, S_ERROR: begin
                    if (!send_command) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Pin drives and flags decode only from registered state, so reset releases the pins at once
    logic clk_low;
    logic dat_low;

    assign clk_low = (state == S_INHIBIT);
    assign dat_low = ((state == S_INHIBIT) && (inhibit_cnt >= INH_W'(INHIBIT_CYCLES / 2)))
                   || (state == S_WAIT_CLK)
                   || ((state == S_DATA) && !image[bit_idx]);

    assign PS2_CLK = clk_low ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_low ? 1'b0 : 1'bz;

    assign busy                          = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
    assign command_was_sent              = (state == S_DONE);
    assign error_communication_timed_out = (state == S_ERROR) && cause_timeout;
    assign error_no_ack                  = (state == S_ERROR) && !cause_timeout;

endmodule

// File: tb/tb_ps2_command_tx_retry.sv
// Bench for ps2_command_tx_retry: a device model drives edge strobes and ACK/NACK,
// results are checked against a per-command outcome model.
module tb_ps2_command_tx_retry;

    localparam int unsigned INH  = 50;
    localparam int unsigned STO  = 300;
    localparam int unsigned XTO  = 200;
    localparam int unsigned MAXR = 2;

    localparam int R_ACK   = 0;
    localparam int R_NACK  = 1;
    localparam int R_STALL = 2;

    int errors = 0;
    int checks = 0;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] the_command;
    logic       send_command;
    logic       ps2_clk_posedge;
    logic       ps2_clk_negedge;
    logic       ps2_dat_in;
    wire        ps2_clk_pin;
    wire        ps2_dat_pin;
    logic       busy;
    logic       command_was_sent;
    logic       error_communication_timed_out;
    logic       error_no_ack;
    logic [1:0] retries_used;

    pullup (ps2_clk_pin);
    pullup (ps2_dat_pin);

    always #5 clk = ~clk;

    ps2_command_tx_retry #(
        .INHIBIT_CYCLES      (INH),
        .START_TIMEOUT_CYCLES(STO),
        .XFER_TIMEOUT_CYCLES (XTO),
        .MAX_RETRIES         (MAXR)
    ) dut (
        .clk                          (clk),
        .reset                        (reset),
        .the_command                  (the_command),
        .send_command                 (send_command),
        .ps2_clk_posedge              (ps2_clk_posedge),
        .ps2_clk_negedge              (ps2_clk_negedge),
        .ps2_dat_in                   (ps2_dat_in),
        .PS2_CLK                      (ps2_clk_pin),
        .PS2_DAT                      (ps2_dat_pin),
        .busy                         (busy),
        .command_was_sent             (command_was_sent),
        .error_communication_timed_out(error_communication_timed_out),
        .error_no_ack                 (error_no_ack),
        .retries_used                 (retries_used)
    );

    // Frame as seen on the wire: start 0, data LSB first, odd parity, stop 1
    function automatic logic [10:0] frame(input logic [7:0] b);
        int          ones;
        logic [10:0] f;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        f[0]   = 1'b0;
        f[8:1] = b;
        f[9]   = ((ones % 2) == 0) ? 1'b1 : 1'b0;
        f[10]  = 1'b1;
        return f;
    endfunction

    // Outcome model: the first ACK among the allowed attempts wins
    task automatic model(input int r0, input int r1, input int r2,
                         output int attempts, output bit ok, output int retries);
        int resp[3];
        resp = '{r0, r1, r2};
        attempts = MAXR + 1;
        ok       = 1'b0;
        retries  = MAXR;
        for (int i = MAXR; i >= 0; i--) begin
            if (resp[i] == R_ACK) begin
                attempts = i + 1;
                ok       = 1'b1;
                retries  = i;
            end
        end
    endtask

    // One device-side attempt: measure request-to-send, clock nedges bits, then answer
    task automatic do_attempt(input logic [7:0] b, input int nedges, input int resp);
        logic [10:0] fr;
        int n, low, datlow;
        fr = frame(b);
        n = 0;
        while (ps2_clk_pin !== 1'b0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ps2_clk_pin !== 1'b0) begin
            errors++;
            $display("FAIL inhibit_start clk=%b expected 0 after %0d cycles", ps2_clk_pin, n);
            return;
        end
        low = 0;
        datlow = 0;
        while (ps2_clk_pin === 1'b0 && low < 1000) begin
            low++;
            if (ps2_dat_pin === 1'b0) datlow++;
            @(negedge clk);
        end
        checks++;
        if (low !== INH) begin
            errors++;
            $display("FAIL inhibit_len got=%0d expected=%0d", low, INH);
        end
        checks++;
        if (datlow !== INH / 2) begin
            errors++;
            $display("FAIL inhibit_dat_low got=%0d expected=%0d", datlow, INH / 2);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_wait_clk got=%b expected=1", busy);
        end
        for (int k = 0; k < nedges; k++) begin
            checks++;
            if (ps2_dat_pin !== fr[k]) begin
                errors++;
                $display("FAIL dat_bit%0d byte=%h got=%b expected=%b", k, b, ps2_dat_pin, fr[k]);
            end
            ps2_clk_negedge = 1'b1;
            @(negedge clk);
            ps2_clk_negedge = 1'b0;
            repeat (2) @(negedge clk);
            if (k < 10) begin
                ps2_clk_posedge = 1'b1;
                @(negedge clk);
                ps2_clk_posedge = 1'b0;
                @(negedge clk);
            end
        end
        if (nedges == 11) begin
            ps2_dat_in      = (resp == R_NACK) ? 1'b1 : 1'b0;
            ps2_clk_posedge = 1'b1;
            @(negedge clk);
            ps2_clk_posedge = 1'b0;
            ps2_dat_in      = 1'b1;
            if (resp == R_ACK) begin
                checks++;
                if (command_was_sent !== 1'b1) begin
                    errors++;
                    $display("FAIL ack_latency sent=%b expected=1", command_was_sent);
                end
            end
        end
    endtask

    // Full command against the outcome model, then drop the request
    task automatic run_command(input logic [7:0] b, input int r0, input int r1, input int r2);
        int attempts, retries, n;
        bit ok;
        int resp[3];
        resp = '{r0, r1, r2};
        model(r0, r1, r2, attempts, ok, retries);
        the_command  = b;
        send_command = 1'b1;
        @(negedge clk);
        the_command = 8'($urandom);
        checks++;
        if (busy !== 1'b1 || ps2_clk_pin !== 1'b0) begin
            errors++;
            $display("FAIL first_cycle busy=%b clk=%b expected 1/0", busy, ps2_clk_pin);
        end
        for (int a = 0; a < attempts; a++) begin
            do_attempt(b, (resp[a] == R_STALL) ? 4 : 11, resp[a]);
        end
        n = 0;
        while (!(command_was_sent || error_no_ack || error_communication_timed_out) && n < 600) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ({command_was_sent, error_no_ack, error_communication_timed_out, busy} !== {ok, !ok, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL result byte=%h sent/noack/tmo/busy got=%b%b%b%b expected=%b%b00",
                     b, command_was_sent, error_no_ack, error_communication_timed_out, busy, ok, !ok);
        end
        checks++;
        if (retries_used !== 2'(retries)) begin
            errors++;
            $display("FAIL retries byte=%h got=%0d expected=%0d", b, retries_used, retries);
        end
        send_command = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, command_was_sent, error_no_ack, error_communication_timed_out} !== 4'b0) begin
            errors++;
            $display("FAIL drop_flags got=%b expected=0000",
                     {busy, command_was_sent, error_no_ack, error_communication_timed_out});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, command_was_sent, error_no_ack, error_communication_timed_out, retries_used} !== 6'b0
            || ps2_clk_pin !== 1'b1 || ps2_dat_pin !== 1'b1) begin
            errors++;
            $display("FAIL reset_state outs=%b clk=%b dat=%b expected 0s and released",
                     {busy, command_was_sent, error_no_ack, error_communication_timed_out, retries_used},
                     ps2_clk_pin, ps2_dat_pin);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ack_send();
        run_command(8'hED, R_ACK, R_ACK, R_ACK);
    endtask

    task automatic test_no_device();
        int n;
        the_command  = 8'hF4;
        send_command = 1'b1;
        n = 0;
        while (!error_communication_timed_out && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n < INH + STO + 1 || n > INH + STO + 3) begin
            errors++;
            $display("FAIL start_timeout cycle got=%0d expected=%0d+-1", n, INH + STO + 2);
        end
        checks++;
        if (error_no_ack !== 1'b0 || busy !== 1'b0 || command_was_sent !== 1'b0
            || ps2_clk_pin !== 1'b1 || ps2_dat_pin !== 1'b1) begin
            errors++;
            $display("FAIL start_timeout_state noack=%b busy=%b sent=%b clk=%b dat=%b expected 0,0,0,1,1",
                     error_no_ack, busy, command_was_sent, ps2_clk_pin, ps2_dat_pin);
        end
        send_command = 1'b0;
        @(negedge clk);
        checks++;
        if (error_communication_timed_out !== 1'b0) begin
            errors++;
            $display("FAIL timeout_drop got=%b expected=0", error_communication_timed_out);
        end
    endtask

    task automatic test_nack_retry();
        run_command(8'hFF, R_NACK, R_NACK, R_ACK);
    endtask

    task automatic test_always_nack();
        run_command(8'hAA, R_NACK, R_NACK, R_NACK);
    endtask

    task automatic test_xfer_timeout();
        run_command(8'h3C, R_STALL, R_ACK, R_ACK);
    endtask

    task automatic test_reset_mid_data();
        the_command  = 8'h00;
        send_command = 1'b1;
        do_attempt(8'h00, 5, R_ACK);
        checks++;
        if (ps2_dat_pin !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_data_pre dat=%b busy=%b expected 0/1", ps2_dat_pin, busy);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (ps2_clk_pin !== 1'b1 || ps2_dat_pin !== 1'b1
            || {busy, command_was_sent, error_no_ack, error_communication_timed_out, retries_used} !== 6'b0) begin
            errors++;
            $display("FAIL async_reset clk=%b dat=%b outs=%b expected released and 0s", ps2_clk_pin, ps2_dat_pin,
                     {busy, command_was_sent, error_no_ack, error_communication_timed_out, retries_used});
        end
        send_command = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_command(8'h5A, R_ACK, R_ACK, R_ACK);
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            run_command(8'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                        int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        reset           = 1'b1;
        the_command     = 8'h00;
        send_command    = 1'b0;
        ps2_clk_posedge = 1'b0;
        ps2_clk_negedge = 1'b0;
        ps2_dat_in      = 1'b1;
        test_reset();
        test_ack_send();
        test_no_device();
        test_nack_retry();
        test_always_nack();
        test_xfer_timeout();
        test_reset_mid_data();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
